// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Instantiators can size DIGITS with bcd_min_digits().
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } bcd_state_e;

  localparam logic [3:0] BcdNine = 4'h9;

  // ceil(bin_w * log10(2)) in fixed point: enough digits to hold 2**bin_w - 1.
  function automatic int unsigned bcd_min_digits(input int unsigned bin_w);
    longint unsigned scaled;
    if (bin_w == 0) begin
      return 1;
    end
    scaled = longint'(bin_w) * 64'd301029996;
    return 32'((scaled + 64'd999999999) / 64'd1000000000);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Inputs are always below 10, so the result never exceeds 4 bits.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one operand bit per clock.
// Results saturate to all-nines with ovf when the operand needs more than DIGITS digits.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(BIN_W - 1);

  bcd_state_e      r_state, w_state_nxt;
  logic [BIN_W-1:0] r_bin, w_bin_nxt;
  logic [BcdW-1:0]  r_work, w_work_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic             r_flag, w_flag_nxt;
  logic [BcdW-1:0]  r_bcd, w_bcd_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_busy, r_done;

  logic [BcdW-1:0]  w_work_adj;
  logic [BcdW-1:0]  w_work_shift;
  logic [BIN_W-1:0] w_bin_shift;
  logic             w_carry;
  logic [BcdW-1:0]  w_nines;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_work[4*g +: 4]),
      .o_digit (w_work_adj[4*g +: 4])
    );
  end

  assign w_nines      = {DIGITS{BcdNine}};
  assign w_carry      = w_work_adj[BcdW-1];
  assign w_work_shift = {w_work_adj[BcdW-2:0], r_bin[BIN_W-1]};
  assign w_bin_shift  = r_bin << 1;

  // The result registers are loaded on the final shift so bcd/ovf are
  // already valid during the DONE cycle while staying purely registered.
  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_flag_nxt  = r_flag;
    w_bcd_nxt   = r_bcd;
    w_ovf_nxt   = r_ovf;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_bin_nxt   = bin;
          w_work_nxt  = '0;
          w_cnt_nxt   = '0;
          w_flag_nxt  = 1'b0;
          w_state_nxt = StShift;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StShift: begin
        w_bin_nxt  = w_bin_shift;
        w_work_nxt = w_work_shift;
        w_cnt_nxt  = r_cnt + 1'b1;
        w_flag_nxt = r_flag | w_carry;
        if (r_cnt == CntLast) begin
          w_bcd_nxt   = w_flag_nxt ? w_nines : w_work_shift;
          w_ovf_nxt   = w_flag_nxt;
          w_state_nxt = StDone;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_bin   <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flag  <= w_flag_nxt;
      r_bcd   <= w_bcd_nxt;
      r_ovf   <= w_ovf_nxt;
      r_busy  <= (w_state_nxt == StShift);
      r_done  <= (w_state_nxt == StDone);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It replaces the single-cycle divide/modulo converter on the display path, which does not scale in width. The block sits between arithmetic result registers and the seven-segment digit multiplexer. It adds a start/done handshake, configurable width and digit count, and overflow saturation.

## Interface

**Parameters**
- `BIN_W`, default 16: binary input width. Must be ≥ 1.
- `DIGITS`, default 5: number of BCD output digits. Must be ≥ 1.

**Ports**
- `clk`, input, 1: system clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: request a conversion. Sampled only when `busy` = 0.
- `bin`, input, `BIN_W`: unsigned operand. Captured in the cycle `start` is accepted.
- `busy`, output, 1: conversion in progress.
- `done`, output, 1: single-cycle pulse. `bcd` and `ovf` are valid and updated in this cycle.
- `bcd`, output, 4·`DIGITS`: result. Digit *k* is in bits [4k+3:4k], and digit 0 is the units digit.
- `ovf`, output, 1: the operand was ≥ 10^`DIGITS`. Sticky until the next `done`.

## Operation

- **Reset value of every output:** `busy`=0, `done`=0, `bcd`=0, `ovf`=0. The internal state is IDLE, the counter is 0, and the shift register is cleared.
- **FSM states:** IDLE, SHIFT, DONE.
  - **IDLE:** if `start`=1, load the binary shift register with `bin`, clear the BCD work register and the overflow flag, set the counter to 0, and go to SHIFT. Otherwise stay in IDLE.
  - **SHIFT:** on each cycle, apply +3 to every BCD work digit that is ≥ 5. Then shift {BCD work, binary} left by 1 and increment the counter.
    - If a 1 is shifted out of the MSB of the top digit, set the overflow flag.
    - After the shift that makes the counter equal to `BIN_W`, go to DONE.
  - **DONE:** copy the work register to `bcd` and the overflow flag to `ovf`, and assert `done` for this one cycle.
    - If `start`=1 in this cycle, accept it exactly as IDLE does and go to SHIFT (back-to-back operation).
    - Otherwise go to IDLE.
- **Overflow:** if the overflow flag is set, `bcd` is forced to all-nines (every digit is 4'h9) and `ovf`=1. `DIGITS` ≥ ceil(`BIN_W`·log10 2) guarantees that `ovf` is never set.
- **Holding outputs:** `bcd` and `ovf` hold their last values between `done` pulses. They change only in a DONE cycle or on `rst`.
- **Ignored start:** `start` while `busy`=1 is ignored. It is not queued.
- **Reset mid-conversion:** `rst` aborts the conversion, returns all outputs to their reset values, and produces no `done`.
- **Width rules:** the counter is $clog2(`BIN_W`+1) bits wide. The add-3 is 4-bit and never carries out of a digit, because digits are < 10 before the shift.

## Timing

- **Start cycle:** `start` is accepted in cycle T.
- **Busy window:** `busy`=1 from cycle T+1 through cycle T+`BIN_W`.
- **Done cycle:** `done`=1 in cycle T+`BIN_W`+1. `bcd` and `ovf` are valid in the same cycle.
- **Busy in DONE:** `busy`=0 in the DONE cycle, so a new `start` can be accepted there.
- **Latency and throughput:** latency from start to done is `BIN_W`+1 cycles. Sustained throughput is one conversion per `BIN_W`+1 cycles.
- **Outputs:** all outputs are registered, with no combinational path from input to output.
- **Operand capture:** `bin` is sampled only in the accept cycle. Later changes to `bin` have no effect.

## Structure

- **Shared package `bcd_pkg`:**
  - FSM state encoding (IDLE, SHIFT, DONE).
  - The BCD nine constant (4'h9).
  - A function returning the minimum digit count for a given width, used by instantiators to size `DIGITS`.
- **Sub-module `bcd_digit_adj`:** combinational 4-bit "if ≥ 5, add 3". It is instantiated `DIGITS` times through a generate loop. The sequential logic stays in the top module.

## Test plan

1. **Zero operand:** `BIN_W`=16, `DIGITS`=5, `bin`=0, pulse `start` → `done` exactly 17 cycles later, `bcd`=20'h00000, `ovf`=0; `busy` high for 16 cycles.
2. **All-nines operand:** `bin`=9999 → `bcd`=20'h09999, `ovf`=0. `bin`=65535 → `bcd`=20'h65535, `ovf`=0.
3. **Overflow saturation:** `DIGITS`=4, `bin`=12345 → `ovf`=1, `bcd`=16'h9999. Next conversion with `bin`=42 → `ovf`=0, `bcd`=16'h0042.
4. **Start while busy, and operand change:** pulse `start` with `bin`=100. Pulse `start` again at cycle T+5 with `bin`=7, and change `bin` mid-conversion → single `done` at T+17 with `bcd`=20'h00100; the second start is ignored.
5. **Back-to-back:** assert `start` in the DONE cycle with `bin`=321 → second `done` 17 cycles after the first, `bcd`=20'h00321. Previous `bcd` is held until then.
6. **Reset mid-conversion:** assert `rst` at T+8 → next cycle all outputs are 0, no `done`. A following `start` with `bin`=5 → `bcd`=20'h00005.
